// File: rtl/cmd_inex_pkg.sv
// Shared definitions for the local-access command arbiter: source ids,
// word widths, arbiter state encoding and the round-robin pick helper.
package cmd_inex_pkg;

    localparam int CMD_W   = 64;
    localparam int TAG_W   = 2;
    localparam int NUM_SRC = 4;

    localparam logic [TAG_W-1:0] SRC_INTERIOR = 2'd0;
    localparam logic [TAG_W-1:0] SRC_EXT1     = 2'd1;
    localparam logic [TAG_W-1:0] SRC_EXT2     = 2'd2;
    localparam logic [TAG_W-1:0] SRC_EXT3     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Returns {found, id}: first requesting source after 'last' in cyclic
    // order last+1 .. last+4. Scanning from the farthest offset down lets
    // the nearest requester overwrite the result.
    function automatic logic [TAG_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [TAG_W-1:0]   last);
        logic [TAG_W:0]   res;
        logic [TAG_W-1:0] idx;
        res = 3'b000;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cmd_fifo_inex.sv
// Single-clock register FIFO for one command source. Pointers carry one
// extra wrap bit so full and empty are distinguished without a counter.
// Writes into a full FIFO and reads from an empty FIFO are ignored.
module cmd_fifo_inex
    import cmd_inex_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CMD_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [CMD_W-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_s;
    logic             pop_s;

    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign push_s  = wr_en & ~full;
    assign pop_s   = rd_en & ~empty;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer advance; reset discards all stored words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/command_arbiter_inex.sv
// Shares the 66-bit local-access command output between the interior
// source (id 0) and three external sources (ids 1..3). Each source has its
// own FIFO; a round-robin arbiter drains them into one registered output
// tagged with the source id, with a programmable idle gap between words.
module command_arbiter_inex
    import cmd_inex_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_GAP    = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] iv_command_from_interior,
    input  logic        i_command_wr_from_interior,
    input  logic [63:0] iv_command_from_external_1,
    input  logic        i_command_wr_from_external_1,
    input  logic [63:0] iv_command_from_external_2,
    input  logic        i_command_wr_from_external_2,
    input  logic [63:0] iv_command_from_external_3,
    input  logic        i_command_wr_from_external_3,
    output logic [65:0] ov_command,
    output logic        o_command_wr,
    output logic [3:0]  ov_fifo_full,
    output logic [31:0] ov_drop_cnt
);

    localparam logic       GAP_EN   = (MIN_GAP > 0) ? 1'b1 : 1'b0;
    localparam logic [7:0] GAP_LAST = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;

    logic [NUM_SRC-1:0] wr_s;
    logic [NUM_SRC-1:0] full_s;
    logic [NUM_SRC-1:0] empty_s;
    logic [NUM_SRC-1:0] pop_s;
    logic [CMD_W-1:0]   in_data_s [NUM_SRC];
    logic [CMD_W-1:0]   rd_data_s [NUM_SRC];
    logic [7:0]         drop_cnt_r [NUM_SRC];

    arb_state_t         state_r;
    arb_state_t         state_nxt_s;
    arb_state_t         arb_state_s;
    logic [TAG_W-1:0]   rr_last_r;
    logic [7:0]         gap_cnt_r;
    logic [7:0]         gap_cnt_nxt_s;
    logic [TAG_W:0]     pick_s;
    logic               arb_en_s;
    logic               load_s;
    logic [65:0]        ov_command_r;
    logic               o_command_wr_r;

    assign wr_s = {i_command_wr_from_external_3, i_command_wr_from_external_2,
                   i_command_wr_from_external_1, i_command_wr_from_interior};
    assign in_data_s[SRC_INTERIOR] = iv_command_from_interior;
    assign in_data_s[SRC_EXT1]     = iv_command_from_external_1;
    assign in_data_s[SRC_EXT2]     = iv_command_from_external_2;
    assign in_data_s[SRC_EXT3]     = iv_command_from_external_3;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        cmd_fifo_inex #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (i_clk),
            .rst     (i_rst),
            .wr_en   (wr_s[g]),
            .wr_data (in_data_s[g]),
            .rd_en   (pop_s[g]),
            .rd_data (rd_data_s[g]),
            .full    (full_s[g]),
            .empty   (empty_s[g])
        );
        assign ov_drop_cnt[8*g +: 8] = drop_cnt_r[g];
    end

    // Grant candidate only sees words already stored, so a same-cycle write
    // into an empty FIFO waits for a later arbitration.
    assign pick_s      = rr_pick(~empty_s, rr_last_r);
    assign arb_state_s = pick_s[TAG_W] ? ST_SEND : ST_IDLE;
    assign load_s      = arb_en_s & pick_s[TAG_W];
    assign pop_s       = load_s ? (4'b0001 << pick_s[TAG_W-1:0]) : 4'b0000;

    assign ov_command   = ov_command_r;
    assign o_command_wr = o_command_wr_r;
    assign ov_fifo_full = full_s;

    // Next-state logic: arbitration is allowed in IDLE, in SEND when no gap
    // is configured, and in the final GAP cycle, which keeps the aggregate
    // rate at exactly one word per (1 + MIN_GAP) cycles.
    always_comb begin
        state_nxt_s   = state_r;
        gap_cnt_nxt_s = gap_cnt_r;
        arb_en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                arb_en_s    = 1'b1;
                state_nxt_s = arb_state_s;
            end
            ST_SEND: begin
                if (GAP_EN) begin
                    state_nxt_s   = ST_GAP;
                    gap_cnt_nxt_s = 8'd0;
                end else begin
                    arb_en_s    = 1'b1;
                    state_nxt_s = arb_state_s;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    arb_en_s    = 1'b1;
                    state_nxt_s = arb_state_s;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, round-robin pointer and registered output word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r        <= ST_IDLE;
            gap_cnt_r      <= 8'd0;
            rr_last_r      <= SRC_EXT3;
            ov_command_r   <= 66'd0;
            o_command_wr_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            gap_cnt_r      <= gap_cnt_nxt_s;
            o_command_wr_r <= load_s;
            if (load_s) begin
                ov_command_r <= {pick_s[TAG_W-1:0], rd_data_s[pick_s[TAG_W-1:0]]};
                rr_last_r    <= pick_s[TAG_W-1:0];
            end
        end
    end

    // Saturating per-source drop counters; full is sampled before any pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                drop_cnt_r[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (wr_s[i] && full_s[i] && (drop_cnt_r[i] != 8'hFF)) begin
                    drop_cnt_r[i] <= drop_cnt_r[i] + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_command_arbiter_inex.sv
// Bench for command_arbiter_inex. A queue-based reference model keeps the
// accepted words per source (with their write cycle); the monitor pops and
// compares every output word, and checks full flags and drop counters.
module tb_command_arbiter_inex;

    typedef struct {
        logic [63:0] word;
        int          wc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] d [4];
    logic [3:0]  w;
    logic [65:0] cmd_o;
    logic        wr_o;
    logic [3:0]  full_o;
    logic [31:0] drop_o;

    // second instance with MIN_GAP = 0, driven on sources 0 and 3 only
    logic [63:0] d2a, d2b, zero64;
    logic        w2a, w2b, zero1;
    logic [65:0] cmd2;
    logic        wr2;
    logic [3:0]  full2;
    logic [31:0] drop2;

    ent_t        q [4][$];
    int          drop_m [4];
    int          rr_m;
    int          cyc = 0;
    int          last_out;
    logic [65:0] last_cmd;
    int          checks = 0;
    int          failures = 0;
    int          out_cnt = 0;

    always #5 clk = ~clk;

    command_arbiter_inex #(.FIFO_DEPTH(4), .MIN_GAP(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .iv_command_from_interior(d[0]),   .i_command_wr_from_interior(w[0]),
        .iv_command_from_external_1(d[1]), .i_command_wr_from_external_1(w[1]),
        .iv_command_from_external_2(d[2]), .i_command_wr_from_external_2(w[2]),
        .iv_command_from_external_3(d[3]), .i_command_wr_from_external_3(w[3]),
        .ov_command(cmd_o), .o_command_wr(wr_o),
        .ov_fifo_full(full_o), .ov_drop_cnt(drop_o)
    );

    command_arbiter_inex #(.FIFO_DEPTH(4), .MIN_GAP(0)) dut2 (
        .i_clk(clk), .i_rst(rst),
        .iv_command_from_interior(d2a),     .i_command_wr_from_interior(w2a),
        .iv_command_from_external_1(zero64), .i_command_wr_from_external_1(zero1),
        .iv_command_from_external_2(zero64), .i_command_wr_from_external_2(zero1),
        .iv_command_from_external_3(d2b),   .i_command_wr_from_external_3(w2b),
        .ov_command(cmd2), .o_command_wr(wr2),
        .ov_fifo_full(full2), .ov_drop_cnt(drop2)
    );

    always @(posedge clk) cyc++;

    task automatic clear_model();
        for (int s = 0; s < 4; s++) begin
            q[s].delete();
            drop_m[s] = 0;
        end
        rr_m     = 3;
        last_out = -10;
        last_cmd = 66'd0;
    endtask

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // One write cycle: strobes are applied for exactly one rising edge and
    // the model decides acceptance from its own occupancy.
    task automatic drive(input logic [3:0] wv, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] e);
        @(negedge clk); #1;
        d[0] = a; d[1] = b; d[2] = c; d[3] = e;
        w = wv;
        for (int s = 0; s < 4; s++) begin
            if (wv[s]) begin
                if (q[s].size() < 4) q[s].push_back('{word: d[s], wc: cyc + 1});
                else if (drop_m[s] < 255) drop_m[s]++;
            end
        end
        @(posedge clk); #1;
        w = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        clear_model();
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", 66'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 66'd0);
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every output word must be the head of the queue of the source
    // the round-robin rule selects among words stored before the grant edge.
    always @(negedge clk) begin
        int e;
        int s;
        logic [65:0] exp;
        if (!rst) begin
            if (wr_o) begin
                e = -1;
                for (int i = 1; i <= 4; i++) begin
                    s = (rr_m + i) % 4;
                    if (e < 0 && q[s].size() > 0 && q[s][0].wc < cyc) e = s;
                end
                checks++;
                if (e < 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got=%h expected=no output", cmd_o);
                end else begin
                    exp = {e[1:0], q[e][0].word};
                    if (cmd_o !== exp) begin
                        failures++;
                        $display("FAIL output_word: got=%h expected=%h", cmd_o, exp);
                    end
                    void'(q[e].pop_front());
                    rr_m = e;
                end
                checks++;
                if (cyc - last_out < 2) begin
                    failures++;
                    $display("FAIL gap: spacing=%0d expected>=2", cyc - last_out);
                end
                last_out = cyc;
                last_cmd = cmd_o;
                out_cnt++;
            end else begin
                checks++;
                if (cmd_o !== last_cmd) begin
                    failures++;
                    $display("FAIL hold: got=%h expected=%h", cmd_o, last_cmd);
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (full_o[k] !== (q[k].size() == 4)) begin
                    failures++;
                    $display("FAIL full_flag src%0d: got=%b expected=%b", k, full_o[k], q[k].size() == 4);
                end
                checks++;
                if (drop_o[8*k +: 8] !== 8'(drop_m[k])) begin
                    failures++;
                    $display("FAIL drop_cnt src%0d: got=%0d expected=%0d", k, drop_o[8*k +: 8], drop_m[k]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        w = 4'b0000;
        for (int s = 0; s < 4; s++) d[s] = 64'd0;
        d2a = 64'd0; d2b = 64'd0; w2a = 1'b0; w2b = 1'b0;
        zero64 = 64'd0; zero1 = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_cmd", cmd_o, 66'd0);
        check("rst_wr", 66'(wr_o), 66'd0);
        check("rst_full", 66'(full_o), 66'd0);
        check("rst_drop", 66'(drop_o), 66'd0);
        #1 rst = 1'b0;

        // Test 1: single word on src 2, visible two edges after its strobe
        drive(4'b0100, 64'd0, 64'd0, 64'hA5, 64'd0);
        @(negedge clk);
        check("t1_not_early", 66'(wr_o), 66'd0);
        @(negedge clk);
        check("t1_wr", 66'(wr_o), 66'd1);
        check("t1_cmd", cmd_o, {2'd2, 64'hA5});

        // Test 2: simultaneous strobes on all four, granted 0..3 two cycles apart
        do_reset();
        drive(4'b1111, 64'h10, 64'h11, 64'h12, 64'h13);
        @(negedge clk);
        check("t2_not_early", 66'(wr_o), 66'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_wr", 66'(wr_o), 66'd1);
            check("t2_cmd", cmd_o, {2'(k), 64'h10 + 64'(k)});
            @(negedge clk);
            check("t2_gap", 66'(wr_o), 66'd0);
        end

        // Randomised traffic checked by the monitor
        for (int i = 0; i < 400; i++) begin
            logic [3:0] wv;
            for (int s = 0; s < 4; s++) wv[s] = ($urandom_range(0, 2) == 0);
            drive(wv, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom});
        end
        drain();

        // Test 3: src 1 burst of six while the arbiter serves 2, 3, 0
        do_reset();
        drive(4'b0010, 64'd0, 64'hB00, 64'd0, 64'd0);
        drive(4'b1101, 64'hC00, 64'd0, 64'hC02, 64'hC03);
        for (int i = 0; i < 6; i++) drive(4'b0010, 64'd0, 64'hB10 + 64'(i), 64'd0, 64'd0);
        @(negedge clk);
        check("t3_full1", 66'(full_o[1]), 66'd1);
        check("t3_drop1", 66'(drop_o[15:8]), 66'd2);
        drain();

        // Test 4: drop counter of src 3 saturates, others untouched
        do_reset();
        for (int i = 0; i < 700; i++) drive(4'b1000, 64'd0, 64'd0, 64'd0, 64'(i));
        @(negedge clk);
        check("t4_sat", 66'(drop_o[31:24]), 66'hFF);
        check("t4_others", 66'(drop_o[23:0]), 66'd0);
        for (int i = 0; i < 20; i++) drive(4'b1000, 64'd0, 64'd0, 64'd0, 64'(i));
        @(negedge clk);
        check("t4_stays", 66'(drop_o[31:24]), 66'hFF);
        drain();

        // Test 5: MIN_GAP = 0 with src 0 and src 3 kept non-empty
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check("t5_wr", 66'(wr2), 66'd1);
                check("t5_id", 66'(cmd2[65:64]), ((i % 2) == 0) ? 66'd0 : 66'd3);
            end
            #1;
            w2a = 1'b1; w2b = 1'b1;
            d2a = 64'(i); d2b = 64'(i + 100);
        end
        @(negedge clk); #1;
        w2a = 1'b0; w2b = 1'b0;

        // Test 6a: asynchronous reset during SEND drops the strobe at once
        do_reset();
        drive(4'b0001, 64'hD0, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("t6_send_wr", 66'(wr_o), 66'd1);
        #1;
        rst = 1'b1;
        clear_model();
        #1;
        check("t6_abort_wr", 66'(wr_o), 66'd0);
        check("t6_abort_cmd", cmd_o, 66'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Test 6b: reset in GAP with three words queued, nothing emitted after
        drive(4'b1111, 64'hE0, 64'hE1, 64'hE2, 64'hE3);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        clear_model();
        #1;
        check("t6_gap_wr", 66'(wr_o), 66'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        n = out_cnt;
        repeat (10) @(negedge clk);
        check("t6_no_output", 66'(out_cnt), 66'(n));
        check("t6_fifo_empty", 66'(full_o), 66'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
